mems_dac_tx: RTL

- Frame sequencer and SPI transmitter for the MEMS mirror quad DAC. It is the consumer end of the DAC command-word ROM.
- It drives the 16-bit word address into the ROM, waits out the ROM read latency, and latches the returned 24-bit command word (6-bit cmd, 2-bit channel, 16-bit code).
- It shifts that word out MSB-first on SYNC_n/SCLK/DIN.
- It advances the address with the init-then-loop ordering the ROM expects: 0 = soft reset, 1 = Vref, then 2..ADDR_LAST repeating.

---
 rtl/mems_dac_pkg.sv | 32 +++
 rtl/mems_spi_shifter.sv | 86 ++++++++
 rtl/mems_dac_tx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mems_dac_pkg.sv
// Shared types and constants for the MEMS mirror quad-DAC transmitter:
// sequencer states, frame width, ROM address map and DAC command codes.
package mems_dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int DAC_WORD_W = 24;

  localparam logic [15:0] ADDR_SOFT_RESET = 16'h0000;
  localparam logic [15:0] ADDR_VREF       = 16'h0001;
  localparam logic [15:0] ADDR_LOOP_START = 16'h0002;

  localparam logic [5:0] CMD_SOFT_RESET   = 6'b001010;
  localparam logic [5:0] CMD_WRITE_UPDATE = 6'b000110;
  localparam logic [7:0] CMD_VREF         = 8'h38;

  // Loop addressing: wrap back to the first data word instead of the init words.
  function automatic logic [15:0] next_addr(input logic [15:0] cur, input logic [15:0] last);
    if (cur == last) begin
      next_addr = ADDR_LOOP_START;
    end else begin
      next_addr = cur + 16'd1;
    end
  endfunction

endpackage

// File: rtl/mems_spi_shifter.sv
// SCLK divider, frame shift register and bit counter. load captures a word,
// start begins clocking it out MSB-first, done marks the last cycle of the frame.
module mems_spi_shifter
  import mems_dac_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = DAC_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic              start,
  output logic              done,
  output logic              sclk,
  output logic              din
);

  localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       BIT_TOP = 5'(WORD_W - 1);

  logic [WORD_W-1:0] shift_r;
  logic [4:0]        bit_cnt_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic              active_r;
  logic              last_r;
  logic              sclk_r;
  logic              din_r;
  logic              tick_s;

  assign tick_s = active_r && (div_cnt_r == DIV_MAX);
  assign done   = tick_s && last_r;
  assign sclk   = sclk_r;
  assign din    = din_r;

  // Divider, shift register and bit counter; the final high phase ends the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r   <= '0;
      bit_cnt_r <= 5'd0;
      div_cnt_r <= '0;
      active_r  <= 1'b0;
      last_r    <= 1'b0;
      sclk_r    <= 1'b1;
      din_r     <= 1'b0;
    end else if (load) begin
      shift_r   <= data;
      din_r     <= data[WORD_W-1];
      bit_cnt_r <= BIT_TOP;
      div_cnt_r <= '0;
      active_r  <= 1'b0;
      last_r    <= 1'b0;
      sclk_r    <= 1'b1;
    end else if (start) begin
      active_r  <= 1'b1;
      sclk_r    <= 1'b0;
      div_cnt_r <= '0;
    end else if (active_r) begin
      if (tick_s) begin
        div_cnt_r <= '0;
        if (last_r) begin
          active_r <= 1'b0;
          last_r   <= 1'b0;
        end else if (sclk_r) begin
          sclk_r <= 1'b0;
        end else begin
          // Rising edge: present the next bit for the DAC's falling-edge sample.
          sclk_r  <= 1'b1;
          shift_r <= {shift_r[WORD_W-2:0], 1'b0};
          din_r   <= shift_r[WORD_W-2];
          if (bit_cnt_r == 5'd0) begin
            last_r <= 1'b1;
          end else begin
            bit_cnt_r <= bit_cnt_r - 5'd1;
          end
        end
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
    end else begin
      div_cnt_r <= '0;
    end
  end

endmodule

// File: rtl/mems_dac_tx.sv
// Frame sequencer for the quad DAC: walks the command ROM (init words, then
// the data loop), waits out ROM latency and frames each word on sync_n.
module mems_dac_tx
  import mems_dac_pkg::*;
#(
  parameter int          CLK_DIV   = 4,
  parameter int          ROM_LAT   = 2,
  parameter int          GAP       = 2,
  parameter logic [15:0] ADDR_LAST = 16'hFFFF,
  parameter int          WORD_W    = DAC_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  output logic [15:0]       addr,
  input  logic [WORD_W-1:0] data,
  output logic              sync_n,
  output logic              sclk,
  output logic              din,
  output logic              busy,
  output logic              frame_done
);

  localparam int               CNT_MAX    = (ROM_LAT > GAP) ? ROM_LAT : GAP;
  localparam int               CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(ROM_LAT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [15:0]      addr_r;
  logic             sync_n_r;
  logic             busy_r;
  logic             frame_done_r;
  logic             restart_pend_r;
  logic             restart_seen_s;
  logic             load_s;
  logic             start_s;
  logic             shift_done_s;

  assign restart_seen_s = restart || restart_pend_r;
  assign load_s         = (state_r == ST_FETCH) && (cnt_r == FETCH_LAST);
  assign start_s        = (state_r == ST_LOAD);

  assign addr       = addr_r;
  assign sync_n     = sync_n_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  mems_spi_shifter #(
    .CLK_DIV (CLK_DIV),
    .WORD_W  (WORD_W)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .data  (data),
    .start (start_s),
    .done  (shift_done_s),
    .sclk  (sclk),
    .din   (din)
  );

  // Frame sequencing; addr only moves at frame end (or while idle on restart).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      addr_r         <= ADDR_SOFT_RESET;
      sync_n_r       <= 1'b1;
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
      restart_pend_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (restart) begin
        restart_pend_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (restart_seen_s) begin
            addr_r         <= ADDR_SOFT_RESET;
            restart_pend_r <= 1'b0;
          end
          if (en) begin
            state_r <= ST_FETCH;
            busy_r  <= 1'b1;
            cnt_r   <= '0;
          end
        end
        ST_FETCH: begin
          if (cnt_r == FETCH_LAST) begin
            state_r  <= ST_LOAD;
            sync_n_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_LOAD: begin
          state_r <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (shift_done_s) begin
            state_r        <= ST_GAP;
            sync_n_r       <= 1'b1;
            frame_done_r   <= 1'b1;
            cnt_r          <= '0;
            restart_pend_r <= 1'b0;
            addr_r         <= restart_seen_s ? ADDR_SOFT_RESET : next_addr(addr_r, ADDR_LAST);
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r <= '0;
            if (en) begin
              state_r <= ST_FETCH;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          sync_n_r <= 1'b1;
          busy_r   <= 1'b0;
          cnt_r    <= '0;
        end
      endcase
    end
  end

endmodule
